// File: rtl/beat_pkg.sv
// Shared definitions for the beat sequencer family: FSM state, the legacy
// switch-decoder rate table and period saturation.
package beat_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Rate table from the fixed-table generator, indexed by a 3-bit switch code.
  localparam int unsigned LEGACY_RATE_N = 8;
  localparam logic [6:0] LEGACY_RATE [LEGACY_RATE_N] = '{
    7'd100, 7'd66, 7'd50, 7'd40, 7'd30, 7'd20, 7'd12, 7'd6
  };

  // A beat needs at least one high and one low cycle, so 0 and 1 become 2.
  function automatic logic [31:0] sat_period(input logic [31:0] p);
    return (p < 32'd2) ? 32'd2 : p;
  endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Control/status bundle between the UI decode logic (master) and the beat
// sequencer (slave).
interface beat_sequencer_if #(
  parameter int CNT_W   = 28,
  parameter int BAR_LEN = 4
);
  import beat_pkg::*;

  localparam int IDX_W = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  // Strobe semantics (no backpressure): period_load and restart are single
  // cycle requests sampled on every rising edge and always accepted; en is a
  // level. Outputs are registered and valid every cycle outside reset.
  logic             en;
  logic [CNT_W-1:0] period;
  logic             period_load;
  logic             restart;
  logic             pulse;
  logic [IDX_W-1:0] beat_idx;
  logic             accent;
  logic             pending;
  state_t           dbg_state;

  modport master (
    output en, period, period_load, restart,
    input  pulse, beat_idx, accent, pending, dbg_state
  );

  modport slave (
    input  en, period, period_load, restart,
    output pulse, beat_idx, accent, pending, dbg_state
  );

endinterface

// File: rtl/beat_counter.sv
// Beat phase counter: counts 0..active-1, flags the wrap edge and decodes
// whether the current phase falls inside the pulse window.
module beat_counter #(
  parameter int CNT_W   = 28,
  parameter int PULSE_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_active,
  output logic             o_wrap,
  output logic             o_pulse_next
);

  localparam logic [CNT_W-1:0] PW = CNT_W'(PULSE_W);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_pw_eff;

  // Comparing against active-1 keeps the wrap free of overflow at full scale.
  assign w_last   = i_active - CNT_W'(1);
  assign w_pw_eff = (PW < w_last) ? PW : w_last;

  assign o_wrap       = i_enable && (r_cnt == w_last);
  assign o_pulse_next = i_enable && (r_cnt < w_pw_eff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_wrap) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Programmable beat generator with deferred rate changes at beat boundaries.
// Define BEAT_SEQ_ACCENT_EN to build the bar position counter and accent flag.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int CNT_W          = 28,
  parameter int PULSE_W        = 1,
  parameter int BAR_LEN        = 4,
  parameter int DEFAULT_PERIOD = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  beat_sequencer_if.slave   bus
);

  localparam int IDX_W = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pending;
  logic             r_pulse;

  logic [CNT_W-1:0] w_sat;
  logic             w_restart;
  logic             w_step;
  logic             w_boundary;
  logic             w_wrap;
  logic             w_pulse_next;

  assign w_sat      = CNT_W'(sat_period(32'(bus.period)));
  // en=0 beats restart; restart beats wrap. Only a plain RUN cycle advances.
  assign w_restart  = bus.en && bus.restart;
  assign w_step     = bus.en && !bus.restart && (r_state == RUN);
  assign w_boundary = w_restart || w_wrap;

  beat_counter #(
    .CNT_W   (CNT_W),
    .PULSE_W (PULSE_W)
  ) u_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (!w_step),
    .i_enable     (w_step),
    .i_active     (r_active),
    .o_wrap       (w_wrap),
    .o_pulse_next (w_pulse_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_active   <= CNT_W'(DEFAULT_PERIOD);
      r_pend_val <= CNT_W'(DEFAULT_PERIOD);
      r_pending  <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_state <= bus.en ? RUN : IDLE;
      r_pulse <= w_pulse_next;

      if (bus.period_load) begin
        r_pend_val <= w_sat;
        r_pending  <= 1'b1;
      end

      // A load coinciding with a boundary is applied directly at that boundary.
      if (w_boundary && bus.period_load) begin
        r_active  <= w_sat;
        r_pending <= 1'b0;
      end else if (w_boundary && r_pending) begin
        r_active  <= r_pend_val;
        r_pending <= 1'b0;
      end else if ((r_state == IDLE) && !w_restart && r_pending && !bus.period_load) begin
        r_active  <= r_pend_val;
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.pulse     = r_pulse;
  assign bus.pending   = r_pending;
  assign bus.dbg_state = r_state;

`ifdef BEAT_SEQ_ACCENT_EN
  logic [IDX_W-1:0] r_beat_idx;
  logic             r_accent;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_idx <= '0;
      r_accent   <= 1'b0;
    end else if (!w_step) begin
      r_beat_idx <= '0;
      r_accent   <= 1'b0;
    end else begin
      r_accent <= w_pulse_next && (r_beat_idx == '0);
      if (w_wrap) begin
        r_beat_idx <= (r_beat_idx == IDX_W'(BAR_LEN - 1)) ? '0 : r_beat_idx + IDX_W'(1);
      end
    end
  end

  assign bus.beat_idx = r_beat_idx;
  assign bus.accent   = r_accent;
`else
  assign bus.beat_idx = '0;
  assign bus.accent   = 1'b0;
`endif

endmodule
